// File: rtl/flog_pkg.sv
// Shared types and constants for the bfloat16 log2 output stage:
// operand classes, special result encodings and FSM state codes.
package flog_pkg;

    localparam int FRAC_WIDTH = 16;
    localparam int EXP_WIDTH  = 8;
    localparam int MAN_WIDTH  = 7;
    localparam int BIAS       = 127;

    typedef enum logic [2:0] {
        FLOG_NORMAL = 3'd0,
        FLOG_ZERO   = 3'd1,
        FLOG_INF    = 3'd2,
        FLOG_NAN    = 3'd3,
        FLOG_NEG    = 3'd4
    } flog_class_t;

    localparam logic [15:0] FLOG_QNAN    = 16'h7FC0;
    localparam logic [15:0] FLOG_POS_INF = 16'h7F80;
    localparam logic [15:0] FLOG_NEG_INF = 16'hFF80;

    // Plain vector codes keep the state register legacy-tool friendly.
    typedef logic [1:0] flog_state_t;
    localparam flog_state_t ST_IDLE  = 2'd0;
    localparam flog_state_t ST_NORM  = 2'd1;
    localparam flog_state_t ST_ROUND = 2'd2;
    localparam flog_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/flog_assemble_if.sv
// Operand/result handshake bundle between the mantissa-log unit (master)
// and the flog_assemble output stage (slave).
interface flog_assemble_if #(
    parameter int FRAC_WIDTH = 16,
    parameter int EXP_WIDTH  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [EXP_WIDTH-1:0]  in_exp;
    logic [2:0]            in_class;
    logic [FRAC_WIDTH-1:0] in_frac;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           result;

    modport master (
        output in_valid, in_exp, in_class, in_frac, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, in_exp, in_class, in_frac, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/flog_assemble.sv
// Combines the unbiased exponent with log2(1.M), normalises the signed
// fixed-point sum one bit per cycle and rounds it to a bfloat16 result.
module flog_assemble
    import flog_pkg::*;
#(
    parameter int FRAC_WIDTH_P = FRAC_WIDTH,
    parameter int EXP_WIDTH_P  = EXP_WIDTH,
    parameter int MAN_WIDTH_P  = MAN_WIDTH,
    parameter int BIAS_P       = BIAS
) (
    input  logic       clk,
    input  logic       rst,
    flog_assemble_if.slave bus
);

    localparam int W  = 8 + FRAC_WIDTH_P;
    localparam int VW = 9 + FRAC_WIDTH_P;

    flog_state_t            state_q,   state_d;
    logic                   sign_q,    sign_d;
    logic [W-1:0]           mag_q,     mag_d;
    logic [EXP_WIDTH_P-1:0] exp_q,     exp_d;
    logic [15:0]            result_q,  result_d;

    // Accept-time conversion of (E - BIAS) . frac into sign/magnitude.
    logic [8:0]             int_part;
    logic [VW-1:0]          fix_val;
    logic [VW-1:0]          fix_abs;
    logic [W-1:0]           mag_init;

    assign int_part = 9'({1'b0, bus.in_exp}) - 9'(BIAS_P);
    assign fix_val  = {int_part, bus.in_frac};
    assign fix_abs  = fix_val[VW-1] ? (~fix_val + 1'b1) : fix_val;
    assign mag_init = fix_abs[W-1:0];

    logic [MAN_WIDTH_P-1:0] man;
    logic                   guard_bit;
    logic                   sticky_bit;
    logic                   round_up;
    logic [MAN_WIDTH_P-1:0] man_rnd;
    logic [EXP_WIDTH_P-1:0] exp_rnd;

    assign man        = mag_q[W-2 -: MAN_WIDTH_P];
    assign guard_bit  = mag_q[W-2-MAN_WIDTH_P];
    assign sticky_bit = |mag_q[W-3-MAN_WIDTH_P:0];
    assign round_up   = guard_bit & (sticky_bit | man[0]);

    // Mantissa overflow on round-up carries into the exponent.
    always_comb begin
        man_rnd = man;
        exp_rnd = exp_q;
        if (round_up) begin
            if (&man) begin
                man_rnd = '0;
                exp_rnd = exp_q + 1'b1;
            end else begin
                man_rnd = man + 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every next-state signal is defaulted to its held value first,
        // so no path through the case below can infer a latch.
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_DONE;
                    case (bus.in_class)
                        FLOG_NORMAL: begin
                            if (mag_init == '0) begin
                                result_d = 16'h0000;
                            end else begin
                                sign_d  = fix_val[VW-1];
                                mag_d   = mag_init;
                                exp_d   = EXP_WIDTH_P'(BIAS_P + 7);
                                state_d = ST_NORM;
                            end
                        end
                        FLOG_ZERO: result_d = FLOG_NEG_INF;
                        FLOG_INF:  result_d = FLOG_POS_INF;
                        default:   result_d = FLOG_QNAN;
                    endcase
                end
            end

            ST_NORM: begin
                if (mag_q[W-1]) begin
                    state_d = ST_ROUND;
                end else begin
                    mag_d = {mag_q[W-2:0], 1'b0};
                    exp_d = exp_q - 1'b1;
                end
            end

            ST_ROUND: begin
                result_d = {sign_q, exp_rnd[7:0], man_rnd};
                state_d  = ST_DONE;
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: all state here is ordinary flops (no memory arrays), so every
    // register is cleared by reset, and each is updated with <= only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            exp_q    <= '0;
            result_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;

endmodule

// File: tb/tb_flog_assemble.sv
// Scoreboard bench for flog_assemble: directed operands push expected
// results and latencies; a negedge monitor pops and compares on handshake.
module tb_flog_assemble;
    import flog_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flog_assemble_if bus ();

    flog_assemble dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [15:0] res;
        int          lat;
        int          acc_edge;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: latency counts the accept edge as edge 1.
    logic prev_v = 1'b0;
    int   first_edge = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) first_edge = cyc;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h, required no output", bus.result);
                end else begin
                    cur = sb.pop_front();
                    check("result", 32'(bus.result), 32'(cur.res));
                    check("latency", 32'(first_edge - cur.acc_edge + 1), 32'(cur.lat));
                end
            end
            prev_v = bus.out_valid;
        end
    end

    task automatic send(input logic [7:0] e, input logic [2:0] c, input logic [15:0] f,
                        input logic [15:0] r, input int lat);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_ready_timeout: got 0, required 1 within 200 cycles");
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_exp   = e;
        bus.in_class = c;
        bus.in_frac  = f;
        sb.push_back('{res: r, lat: lat, acc_edge: cyc + 1});
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_exp    = '0;
        bus.in_class  = '0;
        bus.in_frac   = '0;
        bus.out_ready = 1'b1;
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_result", 32'(bus.result), 32'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Normal operands: (E, class, frac) -> result, latency
        send(8'd127, FLOG_NORMAL, 16'h0000, 16'h0000, 1);
        send(8'd128, FLOG_NORMAL, 16'h0000, 16'h3F80, 10);
        send(8'd126, FLOG_NORMAL, 16'h0000, 16'hBF80, 10);
        send(8'd126, FLOG_NORMAL, 16'h8000, 16'hBF00, 11);
        send(8'd129, FLOG_NORMAL, 16'h8000, 16'h4020, 9);
        send(8'd127, FLOG_NORMAL, 16'hFFFF, 16'h3F80, 11);

        // Special classes and an unused class code
        send(8'd0,   FLOG_ZERO, 16'h0000, FLOG_NEG_INF, 1);
        send(8'd255, FLOG_INF,  16'h0000, FLOG_POS_INF, 1);
        send(8'd130, FLOG_NEG,  16'h1234, FLOG_QNAN,    1);
        send(8'd255, FLOG_NAN,  16'h0001, FLOG_QNAN,    1);
        send(8'd128, 3'd6,      16'h0000, FLOG_QNAN,    1);
        drain();

        // Backpressure: result held, stray in_valid not captured
        bus.out_ready = 1'b0;
        send(8'd0, FLOG_ZERO, 16'h0000, FLOG_NEG_INF, 1);
        bus.in_valid = 1'b1;
        bus.in_class = FLOG_INF;
        bus.in_exp   = 8'd255;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_result", 32'(bus.result), 32'(FLOG_NEG_INF));
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Reset in NORM aborts the operation without a result
        send(8'd130, FLOG_NEG, 16'h0000, FLOG_QNAN, 1);
        drain();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_exp   = 8'd128;
        bus.in_class = FLOG_NORMAL;
        bus.in_frac  = 16'h0000;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("norm_in_ready", 32'(bus.in_ready), 32'd0);
        check("norm_result_prev", 32'(bus.result), 32'(FLOG_QNAN));
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_result", 32'(bus.result), 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (12) @(negedge clk);
        send(8'd128, FLOG_NORMAL, 16'h0000, 16'h3F80, 10);
        drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
